alu_muldiv_iter: RTL
====================

Name: alu_muldiv_iter

Overview:
- Iterative, parametrised XLEN-wide multiply/divide unit implementing the eight RV M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the single-cycle ALU in the execute stage and shares its operand/result conventions, including the Z flag.
- Processes one bit per cycle through a start/done handshake, so the pipeline stalls while the unit is busy.
- Supports kill on pipeline flush.

Parameters:
- XLEN, 32: operand and result width. Must be ≥ 4 and a power of 2.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  launch request. Sampled only when o_ready=1.
- i_kill  input  1  abort any operation in flight; returns to IDLE next edge.
- i_op  input  3  operation code; funct3 encoding, see package.
- i_Ra  input  XLEN  operand rs1 (multiplicand / dividend).
- i_Rb  input  XLEN  operand rs2 (multiplier / divisor).
- o_ready  output  1  high in IDLE and DONE; a new start is accepted.
- o_done  output  1  one-cycle pulse; o_Rc is valid in this cycle.
- o_Rc  output  XLEN  result. Held from o_done until the next accepted start.
- o_Z  output  1  (o_Rc == 0), combinational from o_Rc.

Behaviour:
- Reset, asynchronous and active-high:
  - state=IDLE, counter=0, o_Rc=0, o_done=0, o_ready=1.
  - The internal accumulator, operand and sign registers are cleared to 0.
- FSM states are IDLE, BUSY and DONE.
- IDLE, on i_start & !i_kill:
  - Latch the op, the operand magnitudes, the result-sign flag and counter=XLEN-1.
  - Normal case: go to BUSY.
  - Special case: go to DONE with the result precomputed.
- BUSY:
  - Runs one iteration per cycle. Moves to DONE on the edge where counter==0, so BUSY lasts exactly XLEN cycles.
  - On i_kill: go to IDLE. o_done is not raised and o_Rc keeps its previous value.
- DONE:
  - Asserts o_done=1 for exactly one cycle and drives o_Rc.
  - Next state is BUSY/DONE if i_start & !i_kill (back-to-back start accepted), otherwise IDLE.
- Latency from the accepting edge to the o_done cycle:
  - XLEN+1 cycles for normal operations.
  - 1 cycle for the special cases.
- i_start while BUSY is ignored (o_ready=0). i_kill while IDLE or DONE has no effect beyond cancelling a simultaneous start.
- Multiply, shift-add on the 2*XLEN product:
  - MUL/MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both operands unsigned.
  - Magnitudes are multiplied unsigned. The 2*XLEN product is negated in DONE if the sign flag is set.
  - MUL returns product[XLEN-1:0]. The three MULH variants return product[2*XLEN-1:XLEN].
- Divide, restoring, one quotient bit per cycle, on magnitudes:
  - Quotient sign = sign(rs1) XOR sign(rs2) for DIV.
  - Remainder sign = sign(rs1) for REM.
  - Unsigned forms apply no sign fix.
- Special cases, resolved in IDLE without entering BUSY:
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give rs1.
  - Signed overflow (rs1 = 1 followed by XLEN-1 zeros, i.e. the most-negative value, and rs2 = all ones) for DIV/REM: DIV gives rs1, REM gives 0.
- All arithmetic is modulo 2^XLEN or 2^(2*XLEN). Counter width is clog2(XLEN).
- Reset during BUSY aborts immediately. No o_done pulse is generated.

Decomposition:
- Shared package/header alongside ALU_DEFINES, holding the op constants:
  - MD_MUL=3'd0, MD_MULH=3'd1, MD_MULHSU=3'd2, MD_MULHU=3'd3
  - MD_DIV=3'd4, MD_DIVU=3'd5, MD_REM=3'd6, MD_REMU=3'd7
  - FSM state encodings MD_IDLE/MD_BUSY/MD_DONE.
  - Helper macro for is_div = op[2] and is_signed decode.
- One natural sub-module: muldiv_sign_prep, a combinational block producing the operand magnitudes and the result-sign flags from op, Ra and Rb. The FSM, datapath and post-negation stay in the top module.

Test Plan:
- MUL: 7 × -3 (0x00000007, 0xFFFFFFFD) → o_done at cycle 33 after start, o_Rc=0xFFFFFFEB, o_Z=0. The same operands with MULH → 0xFFFFFFFF.
- MULHU / MULHSU: MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV/REM: -7 ÷ 2 → DIV 0xFFFFFFFD, REM 0xFFFFFFFF. DIVU 100 ÷ 7 → 14; REMU 100 ÷ 7 → 2.
- Special cases: DIVU 5 ÷ 0 → 0xFFFFFFFF. REM 5 ÷ 0 → 5. DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000 and REM → 0. Each with o_done in the cycle after start.
- Kill and illegal start: i_kill at BUSY cycle 10 → IDLE next edge, no o_done, o_Rc unchanged. A start pulsed during BUSY is ignored and the result matches the first op.
- Back-to-back and reset: i_start held in DONE launches the second op with no IDLE gap. Asserting i_rst mid-BUSY → o_Rc=0, o_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_muldiv_iter_pkg.sv
// Shared op codes, FSM states and decode helpers for the iterative mul/div unit.
package alu_muldiv_iter_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // DIV and REM are the signed divide forms (funct3 bit 0 clear).
  function automatic logic is_signed_div(input logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/alu_muldiv_iter_sign_prep.sv
// Operand magnitudes and result-sign flag for the mul/div datapath.
module muldiv_sign_prep
  import alu_muldiv_iter_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] ra,
  input  logic [XLEN-1:0] rb,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            neg_res
);

  logic a_sgn, b_sgn, a_neg, b_neg;

  always_comb begin
    a_sgn   = is_div(op) ? is_signed_div(op) : (op != MD_MULHU);
    b_sgn   = is_div(op) ? is_signed_div(op) : ((op == MD_MUL) || (op == MD_MULH));
    a_neg   = a_sgn && ra[XLEN-1];
    b_neg   = b_sgn && rb[XLEN-1];
    mag_a   = a_neg ? -ra : ra;
    mag_b   = b_neg ? -rb : rb;
    // Remainder takes the dividend's sign; everything else the XOR.
    neg_res = is_rem(op) ? a_neg : (a_neg ^ b_neg);
  end

endmodule

// File: rtl/alu_muldiv_iter.sv
// Iterative RV M-extension multiply/divide unit, one bit per cycle, start/done handshake.
module alu_muldiv_iter
  import alu_muldiv_iter_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_kill,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_Ra,
  input  logic [XLEN-1:0] i_Rb,
  output logic            o_ready,
  output logic            o_done,
  output logic [XLEN-1:0] o_Rc,
  output logic            o_Z
);

  localparam int unsigned CW = $clog2(XLEN);

  md_state_t         state, state_next;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, iter_next, prod;
  logic [XLEN-1:0]   opnd, mag_a, mag_b, spec_val, res_val, quo, rem;
  logic [XLEN:0]     mul_sum, div_diff;
  logic [2:0]        op_q;
  logic              neg_q, neg_res, accept, spec_hit, div_zero, div_ovf;

  muldiv_sign_prep #(.XLEN(XLEN)) u_sign_prep (
    .op      (i_op),
    .ra      (i_Ra),
    .rb      (i_Rb),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .neg_res (neg_res)
  );

  always_comb begin
    div_zero = is_div(i_op) && (i_Rb == '0);
    div_ovf  = is_signed_div(i_op) && (i_Ra == {1'b1, {(XLEN-1){1'b0}}}) && (i_Rb == '1);
    spec_hit = div_zero || div_ovf;
    spec_val = '0;
    if (div_zero)     spec_val = is_rem(i_op) ? i_Ra : '1;
    else if (div_ovf) spec_val = is_rem(i_op) ? '0 : i_Ra;
  end

  // acc holds {remainder, dividend/quotient} when dividing, {product_hi, multiplier/product_lo} when multiplying.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    if (is_div(op_q))
      iter_next = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      iter_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
  end

  // Final result is formed from the last iteration so it can be registered on the edge entering DONE.
  always_comb begin
    prod = neg_q ? -iter_next : iter_next;
    quo  = iter_next[XLEN-1:0];
    rem  = iter_next[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:                      res_val = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res_val = prod[2*XLEN-1:XLEN];
      MD_DIV:                      res_val = neg_q ? -quo : quo;
      MD_REM:                      res_val = neg_q ? -rem : rem;
      MD_DIVU:                     res_val = quo;
      default:                     res_val = rem;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= MD_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    o_ready    = 1'b0;
    o_done     = 1'b0;
    case (state)
      MD_IDLE, MD_DONE: begin
        o_ready    = 1'b1;
        o_done     = (state == MD_DONE);
        accept     = i_start && !i_kill;
        state_next = accept ? (spec_hit ? MD_DONE : MD_BUSY) : MD_IDLE;
      end
      MD_BUSY: begin
        if (i_kill)          state_next = MD_IDLE;
        else if (cnt == '0)  state_next = MD_DONE;
      end
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc   <= '0;
      opnd  <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      cnt   <= '0;
      o_Rc  <= '0;
    end else if (accept) begin
      op_q  <= i_op;
      neg_q <= neg_res;
      acc   <= {{XLEN{1'b0}}, mag_a};
      opnd  <= mag_b;
      cnt   <= CW'(XLEN - 1);
      if (spec_hit) o_Rc <= spec_val;
    end else if ((state == MD_BUSY) && !i_kill) begin
      acc <= iter_next;
      cnt <= cnt - CW'(1);
      if (cnt == '0) o_Rc <= res_val;
    end
  end

  assign o_Z = (o_Rc == '0);

endmodule
